// File: rtl/systolic_wrap_c_sram_flat.sv
// C = W*X on an output-stationary MxN MAC array. Results go to an internal
// C SRAM (CPU read port) and to a flat mirror with per-entry valid flags.
module systolic_wrap_c_sram_flat #(
    parameter int M                 = 8,
    parameter int N                 = 8,
    parameter int KMAX              = 1024,
    parameter int DATA_W            = 32,
    parameter int BYTE_W            = DATA_W / 8,
    parameter int CONFLICT_POLICY_C = 1,
    parameter int RW                = (M > 1) ? $clog2(M) : 1,
    parameter int CW                = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              K_len,
    output logic                     busy,
    output logic                     done,
    input  logic [M*KMAX*DATA_W-1:0] W_tile_flat,
    input  logic [KMAX*N*DATA_W-1:0] X_tile_flat,
    input  logic                     c_rd_en,
    input  logic                     c_rd_re,
    input  logic [RW-1:0]            c_rd_row,
    input  logic [CW-1:0]            c_rd_col,
    output logic [DATA_W-1:0]        c_rd_rdata,
    output logic                     c_rd_rvalid,
    output logic [M*N*DATA_W-1:0]    c_out_flat_o,
    output logic [M*N-1:0]           c_valid_flat_o,
    output logic                     C_valid
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_CLEAR | zero accumulators and valid flags
    // S_FEED  | skewed operand feed, PEs accumulate
    // S_WRITE | one C word per cycle into SRAM and flat mirror
    // S_DONE  | done pulse
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_WRITE, S_DONE} state_t;

    localparam int MN  = M * N;
    localparam int IW  = (MN > 1) ? $clog2(MN) : 1;
    localparam int WAW = $clog2(M * KMAX * DATA_W);
    localparam int XAW = $clog2(KMAX * N * DATA_W);
    localparam int OAW = $clog2(MN * DATA_W);
    localparam bit RD_WINS = (CONFLICT_POLICY_C == 0);

    state_t              r_state, w_state_nxt;
    logic [15:0]         r_keff, r_flen_last, r_t, w_keff;
    logic [IW-1:0]       r_widx, r_pend_addr, w_req_addr;
    logic [MN-1:0]       r_valid_flat;
    logic [MN*DATA_W-1:0] r_c_flat;
    logic                r_pend, r_rd_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_mem [MN];
    logic [BYTE_W-1:0]   w_be;
    logic                w_req, w_eng_wr, w_svc_pend, w_svc_new, w_set_pend, w_wr_last;

    logic [DATA_W-1:0]   r_acc [MN];
    logic [DATA_W-1:0]   r_a [MN], r_b [MN], w_a_in [MN], w_b_in [MN];
    logic                r_av [MN], r_bv [MN], w_av_in [MN], w_bv_in [MN];
    logic [DATA_W-1:0]   w_feed_a [M], w_feed_b [N];
    logic [M-1:0]        w_feed_av;
    logic [N-1:0]        w_feed_bv;

    assign w_keff     = (K_len > 16'(KMAX)) ? 16'(KMAX) : K_len;
    assign w_req      = c_rd_en & c_rd_re;
    assign w_req_addr = IW'(c_rd_row) * IW'(N) + IW'(c_rd_col);
    assign w_wr_last  = (r_widx == IW'(MN - 1));
    assign w_be       = '1;

    // With read-wins policy the engine write yields to any CPU request.
    assign w_eng_wr   = (r_state == S_WRITE) && !(RD_WINS && w_req);
    assign w_svc_pend = r_pend && !w_eng_wr;
    assign w_svc_new  = w_req && !r_pend && !w_eng_wr;
    assign w_set_pend = w_req && !r_pend && w_eng_wr;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = (r_keff == 16'd0) ? S_WRITE : S_FEED;
            S_FEED:  if (r_t == r_flen_last) w_state_nxt = S_WRITE;
            S_WRITE: if (w_eng_wr && w_wr_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Row i sees W[i][t-i], column j sees X[t-j][j].
    always_comb begin
        for (int i = 0; i < M; i++) begin
            w_feed_a[i]  = '0;
            w_feed_av[i] = 1'b0;
            if (r_state == S_FEED && int'(r_t) >= i && int'(r_t) - i < int'(r_keff)) begin
                w_feed_av[i] = 1'b1;
                w_feed_a[i]  = W_tile_flat[WAW'((i * KMAX + int'(r_t) - i) * DATA_W) +: DATA_W];
            end
        end
        for (int j = 0; j < N; j++) begin
            w_feed_b[j]  = '0;
            w_feed_bv[j] = 1'b0;
            if (r_state == S_FEED && int'(r_t) >= j && int'(r_t) - j < int'(r_keff)) begin
                w_feed_bv[j] = 1'b1;
                w_feed_b[j]  = X_tile_flat[XAW'(((int'(r_t) - j) * N + j) * DATA_W) +: DATA_W];
            end
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            localparam int P = gi * N + gj;
            if (gj == 0) begin : g_a_edge
                assign w_a_in[P]  = w_feed_a[gi];
                assign w_av_in[P] = w_feed_av[gi];
            end else begin : g_a_int
                assign w_a_in[P]  = r_a[P-1];
                assign w_av_in[P] = r_av[P-1];
            end
            if (gi == 0) begin : g_b_edge
                assign w_b_in[P]  = w_feed_b[gj];
                assign w_bv_in[P] = w_feed_bv[gj];
            end else begin : g_b_int
                assign w_b_in[P]  = r_b[P-N];
                assign w_bv_in[P] = r_bv[P-N];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < MN; p++) begin
                r_acc[p] <= '0;
                r_a[p]   <= '0;
                r_b[p]   <= '0;
                r_av[p]  <= 1'b0;
                r_bv[p]  <= 1'b0;
            end
        end else if (r_state == S_CLEAR) begin
            for (int p = 0; p < MN; p++) begin
                r_acc[p] <= '0;
                r_a[p]   <= '0;
                r_b[p]   <= '0;
                r_av[p]  <= 1'b0;
                r_bv[p]  <= 1'b0;
            end
        end else begin
            for (int p = 0; p < MN; p++) begin
                r_a[p]  <= w_a_in[p];
                r_b[p]  <= w_b_in[p];
                r_av[p] <= w_av_in[p];
                r_bv[p] <= w_bv_in[p];
                if (w_av_in[p] && w_bv_in[p])
                    r_acc[p] <= r_acc[p] + w_a_in[p] * w_b_in[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_eng_wr) begin
            for (int b = 0; b < BYTE_W; b++)
                if (w_be[b]) r_mem[r_widx][b*8 +: 8] <= r_acc[r_widx][b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_keff       <= '0;
            r_flen_last  <= '0;
            r_t          <= '0;
            r_widx       <= '0;
            r_valid_flat <= '0;
            r_c_flat     <= '0;
            r_pend       <= 1'b0;
            r_pend_addr  <= '0;
            r_rd_rvalid  <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start) begin
                r_keff       <= w_keff;
                r_flen_last  <= w_keff + 16'(M + N - 3);
                r_valid_flat <= '0;
            end
            r_t <= (r_state == S_FEED) ? r_t + 16'd1 : 16'd0;
            if (r_state != S_WRITE) begin
                r_widx <= '0;
            end else if (w_eng_wr) begin
                r_widx                                     <= r_widx + 1'b1;
                r_valid_flat[r_widx]                       <= 1'b1;
                r_c_flat[OAW'(int'(r_widx) * DATA_W) +: DATA_W] <= r_acc[r_widx];
            end
            r_rd_rvalid <= w_svc_pend | w_svc_new;
            if (w_svc_pend)     r_rdata <= r_mem[r_pend_addr];
            else if (w_svc_new) r_rdata <= r_mem[w_req_addr];
            if (w_set_pend) begin
                r_pend      <= 1'b1;
                r_pend_addr <= w_req_addr;
            end else if (w_svc_pend) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign C_valid        = &r_valid_flat;
    assign c_valid_flat_o = r_valid_flat;
    assign c_out_flat_o   = r_c_flat;
    assign c_rd_rdata     = r_rdata;
    assign c_rd_rvalid    = r_rd_rvalid;

endmodule

// File: tb/tb_systolic_wrap_c_sram_flat.sv
// Bench for systolic_wrap_c_sram_flat: job-level timing/result model plus
// a CPU read scoreboard, checked every cycle on the falling edge.
`timescale 1ns/1ps
module tb_systolic_wrap_c_sram_flat;
    localparam int M = 8, N = 8, KMAX = 1024, DW = 32, MN = M * N;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [15:0] K_len = '0;
    logic busy, done, rvalid, C_valid;
    logic [M*KMAX*DW-1:0] W_flat;
    logic [KMAX*N*DW-1:0] X_flat;
    logic rd_en = 1'b0, rd_re = 1'b0;
    logic [2:0] rd_row = '0, rd_col = '0;
    logic [DW-1:0] rdata;
    logic [MN*DW-1:0] c_out;
    logic [MN-1:0] cvf;

    systolic_wrap_c_sram_flat dut (
        .clk(clk), .rst(rst), .start(start), .K_len(K_len), .busy(busy), .done(done),
        .W_tile_flat(W_flat), .X_tile_flat(X_flat),
        .c_rd_en(rd_en), .c_rd_re(rd_re), .c_rd_row(rd_row), .c_rd_col(rd_col),
        .c_rd_rdata(rdata), .c_rd_rvalid(rvalid),
        .c_out_flat_o(c_out), .c_valid_flat_o(cvf), .C_valid(C_valid)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] Wm [M][KMAX];
    logic [DW-1:0] Xm [KMAX][N];
    logic [DW-1:0] gold [MN];
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, m_rem = 0, ke = 0;
    bit m_cv = 1'b0;
    typedef struct { int cyc; logic [DW-1:0] data; } rd_t;
    rd_t rq [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Job model: a job lasts CLEAR + FEED(Keff+M+N-2, or 0) + WRITE(M*N) + DONE.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rem = 0;
            m_cv  = 1'b0;
            rq.delete();
        end else begin
            cyc = cyc + 1;
            if (m_rem == 1) m_cv = 1'b1;
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end else if (start) begin
                ke = (int'(K_len) > KMAX) ? KMAX : int'(K_len);
                for (int i = 0; i < M; i++)
                    for (int j = 0; j < N; j++) begin
                        gold[i*N+j] = '0;
                        for (int k = 0; k < ke; k++) gold[i*N+j] += Wm[i][k] * Xm[k][j];
                    end
                m_rem = 2 + ((ke == 0) ? 0 : ke + M + N - 2) + MN;
                m_cv  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("busy", busy, m_rem > 0);
            chk("done", done, m_rem == 1);
            chk("C_valid", C_valid, m_cv || m_rem == 1);
            if (m_cv || m_rem == 1) begin
                int bad;
                bad = -1;
                for (int p = 0; p < MN; p++)
                    if (c_out[p*DW +: DW] !== gold[p] && bad < 0) bad = p;
                n_cmp++;
                if (bad >= 0) begin
                    n_fail++;
                    $display("FAIL c_out[%0d]: got %h expected %h", bad, c_out[bad*DW +: DW], gold[bad]);
                end
                chk("valid_flat_all", cvf, {MN{1'b1}});
            end else if (m_rem >= 2 && m_rem <= MN + 1) begin
                chk("valid_flat_count", $countones(cvf), MN + 1 - m_rem);
            end else begin
                chk("valid_flat_zero", cvf, '0);
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("rd_missing_cycle", cyc, rq[0].cyc);
                void'(rq.pop_front());
            end
            if (rvalid) begin
                if (rq.size() == 0) begin
                    chk("rd_unexpected", 1'b1, 1'b0);
                end else begin
                    chk("rd_latency", cyc, rq[0].cyc);
                    chk("rd_data", rdata, rq[0].data);
                    void'(rq.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int r = 0; r < M; r++)
            for (int k = 0; k < KMAX; k++) W_flat[18'((r*KMAX+k)*DW) +: DW] = Wm[r][k];
        for (int k = 0; k < KMAX; k++)
            for (int n = 0; n < N; n++) X_flat[18'((k*N+n)*DW) +: DW] = Xm[k][n];
    endtask

    task automatic clear_tiles();
        for (int r = 0; r < M; r++) for (int k = 0; k < KMAX; k++) Wm[r][k] = '0;
        for (int k = 0; k < KMAX; k++) for (int n = 0; n < N; n++) Xm[k][n] = '0;
    endtask

    task automatic basic_tiles();
        clear_tiles();
        for (int r = 0; r < M; r++) for (int k = 0; k < 4; k++) Wm[r][k] = DW'(r + k + 1);
        for (int k = 0; k < 4; k++) for (int n = 0; n < N; n++) Xm[k][n] = DW'((k + 1) * (n + 1));
        pack();
    endtask

    task automatic go(input int k);
        K_len = 16'(k);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin step(); n++; end
        chk("done_seen", done, 1'b1);
        step();
    endtask

    task automatic rd(input int r, input int c, input logic [DW-1:0] expv);
        rd_en = 1'b1; rd_re = 1'b1; rd_row = 3'(r); rd_col = 3'(c);
        rq.push_back('{(m_rem >= 2 && m_rem <= MN + 1) ? cyc + m_rem : cyc + 1, expv});
        step();
        rd_en = 1'b0; rd_re = 1'b0;
    endtask

    task automatic read_all();
        for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) rd(r, c, gold[r*N+c]);
        repeat (3) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_rvalid"}, rvalid, 1'b0);
        chk({tag, "_rdata"}, rdata, '0);
        chk({tag, "_C_valid"}, C_valid, 1'b0);
        chk({tag, "_cvf"}, cvf, '0);
        chk({tag, "_cout_zero"}, (c_out == '0), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        W_flat = '0;
        X_flat = '0;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst = 1'b1;
        step();

        // basic 8x8, K=4
        basic_tiles();
        go(4);
        wait_done(2000);
        chk("gold00", gold[0], 32'd30);
        chk("gold77", gold[63], 32'd800);
        chk("cout00", c_out[0 +: DW], 32'd30);
        chk("cout77", c_out[63*DW +: DW], 32'd800);
        read_all();
        rd(0, 0, 32'd30);
        rd(7, 7, 32'd800);
        rd_en = 1'b1; rd_re = 1'b0; step(); rd_en = 1'b0;
        repeat (3) step();

        // overflow and sign
        clear_tiles();
        Wm[0][0] = 32'h7FFF_FFFF; Xm[0][0] = 32'd2; pack();
        go(1);
        wait_done(2000);
        rd(0, 0, 32'hFFFF_FFFE);
        rd(1, 1, 32'd0);
        repeat (3) step();
        Wm[0][0] = -32'd3; Xm[0][0] = 32'd5; pack();
        go(1);
        wait_done(2000);
        rd(0, 0, 32'hFFFF_FFF1);
        repeat (3) step();

        // K=0: everything zero
        basic_tiles();
        go(0);
        wait_done(2000);
        chk("k0_cout_zero", (c_out == '0), 1'b1);
        read_all();

        // K beyond KMAX clamps to KMAX
        for (int r = 0; r < M; r++)
            for (int k = 0; k < KMAX; k++) Wm[r][k] = DW'(r * 1000003 + k * 7919 + 1);
        for (int k = 0; k < KMAX; k++)
            for (int n = 0; n < N; n++) Xm[k][n] = DW'(k * 31 - n * 17 + 5);
        pack();
        go(2000);
        wait_done(3000);
        read_all();

        // second start while busy is ignored; read during WRITE is deferred
        basic_tiles();
        go(4);
        repeat (3) step();
        go(7);
        begin
            int n;
            n = 0;
            while (m_rem != 40 && n < 300) begin step(); n++; end
            chk("reach_write", m_rem, 40);
        end
        rd(3, 5, gold[3*N+5]);
        wait_done(2000);
        chk("cout35", c_out[(3*N+5)*DW +: DW], DW'(30 * 4 + 15 * 2 + 6 * 1 + 3 * 0) + DW'(4*1*6 + 5*2*6 + 6*3*6 + 7*4*6) - DW'(30 * 4 + 15 * 2 + 6 * 1));
        repeat (5) step();

        // reset mid-FEED, then a clean job
        go(100);
        repeat (20) step();
        #2 rst = 1'b0;
        #1 chk_reset_outputs("midfeed");
        step();
        rst = 1'b1;
        step();
        go(4);
        wait_done(2000);
        chk("post_rst_cout77", c_out[63*DW +: DW], 32'd800);
        read_all();

        chk("rd_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_wrap_c_sram_flat.md
Name: systolic_wrap_c_sram_flat

Overview:
Integer matrix-multiply engine wrapper that computes C = W·X. W is an M×K tile and X is a K×N tile; both arrive on flat buses. The block uses an output-stationary M×N MAC array, writes the M×N results into an internal C SRAM, and exposes a CPU read port plus a flat mirror of C. It sits between a tile loader and a CPU or host that reads results after done.

Parameters:
- M, 8: rows of C and W.
- N, 8: columns of C and X.
- KMAX, 1024: maximum reduction length; sizes the flat input buses.
- DATA_W, 32: word width of all elements.
- BYTE_W, DATA_W/8: C SRAM byte-enable width. Writes are always full-word (all byte enables asserted).
- CONFLICT_POLICY_C, 1: rule for a CPU read that coincides with an engine write. 1 = engine write wins. 0 = CPU read wins.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that launches a computation.
- K_len  in  16  reduction length, sampled on start.
- busy  out  1  high while a job is in progress.
- done  out  1  one-cycle completion pulse.
- W_tile_flat  in  M*KMAX*DATA_W  W[r][k] at bit offset (r*KMAX+k)*DATA_W.
- X_tile_flat  in  KMAX*N*DATA_W  X[k][n] at bit offset (k*N+n)*DATA_W.
- c_rd_en  in  1  read enable.
- c_rd_re  in  1  read strobe. A request exists only when c_rd_en and c_rd_re are both high.
- c_rd_row  in  clog2(M) (min 1)  read row.
- c_rd_col  in  clog2(N) (min 1)  read column.
- c_rd_rdata  out  DATA_W  read data.
- c_rd_rvalid  out  1  read data valid pulse.
- c_out_flat_o  out  M*N*DATA_W  C[i][j] at bit offset (i*N+j)*DATA_W.
- c_valid_flat_o  out  M*N  per-entry written flag, bit i*N+j.
- C_valid  out  1  all M*N entries are valid.

Behaviour:
- Reset (rst low, asynchronous) forces the following; SRAM contents are not reset:
  - FSM to IDLE.
  - busy, done, c_rd_rvalid = 0.
  - c_rd_rdata = 0.
  - c_out_flat_o = 0.
  - c_valid_flat_o = 0 and C_valid = 0.
  - any pending read and all in-flight work dropped.
- Arithmetic:
  - C[i][j] = Σ_{k<Keff} W[i][k]·X[k][j].
  - Each product is signed DATA_W×DATA_W; only the low DATA_W bits are kept.
  - Accumulation is mod 2^DATA_W (wraps, no saturation).
  - Keff = min(K_len, KMAX).
- FSM: IDLE → CLEAR → FEED → WRITE → DONE → IDLE.
  - IDLE: start latches Keff and moves to CLEAR. start is ignored in any other state.
  - CLEAR (1 cycle): accumulators are zeroed, c_valid_flat_o is cleared, C_valid drops.
  - FEED (Keff+M+N-2 cycles, 0 cycles if Keff=0): skewed feed. Row i receives W[i][k] delayed by i cycles. Column j receives X[k][j] delayed by j cycles. Operands propagate one PE per cycle right and down, and each PE MACs on every valid pair.
  - WRITE (M*N cycles nominal): one C word per cycle, row-major, into the SRAM and into c_out_flat_o. The matching c_valid_flat_o bit sets the same cycle.
  - DONE (1 cycle): done=1. C_valid=1, held until the next start or reset.
- busy is 1 from the cycle after an accepted start through the DONE cycle inclusive.
- CPU read:
  - A request is sampled at a clock edge; c_rd_rdata and c_rd_rvalid=1 follow on the next edge.
  - rvalid is a one-cycle pulse.
  - Reads are legal in any state and return the current SRAM contents, before any same-cycle write.
- Conflict in WRITE, when a CPU request and an engine write land on the same cycle:
  - Policy 1: the request is held pending and serviced on the first cycle with no engine write, so rvalid is delayed. Only one read is pending at a time; new requests are ignored while one is pending.
  - Policy 0: the read is serviced and the engine write stalls one cycle.
- Reads of never-written entries return undefined SRAM data.
- Reset mid-FEED or mid-WRITE aborts the job: no done pulse, busy drops immediately.

Test Plan:
- W[i][k]=i+k+1, X[k][n]=(k+1)(n+1), K_len=4, 8×8, then read all 64 via the CPU port → C[0][0]=30, C[7][7]=800. Every entry equals the golden value, done pulses once, C_valid=1, c_out_flat_o matches.
- Overflow and sign: K_len=1, W[0][0]=0x7FFFFFFF, X[0][0]=2 → C[0][0]=0xFFFFFFFE. Then W[0][0]=-3, X[0][0]=5 → 0xFFFFFFF1.
- K_len=0 → busy then done after CLEAR+WRITE+DONE. All C = 0 and C_valid=1.
- K_len=2000 → treated as KMAX=1024; result matches a golden model using k<1024.
- start pulsed while busy → ignored; only one done pulse, results from the first job. CPU read issued during WRITE with policy 1 → rvalid arrives late but with correct data.
- rst asserted mid-FEED → busy, done, valid outputs = 0 immediately. A fresh start then completes correctly.
